// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and occupancy width for the skid register stage
// State bits are {skidValid, mainValid}, so 2'b10 (skid without main) is the illegal code.
package pipe_pkg;
  localparam int OCC_W = 2;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } state_t;
endpackage

// File: rtl/reg_nb_en.sv
// reg_nb_en: WIDTH-bit register with load enable and async active-high reset to RESET_VAL
// Ports: clk, rst (async, active-high), en (load), d (next value), q (held value).
module reg_nb_en #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= RESET_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: parametrised pipeline register with valid/ready handshake, 2-entry skid buffer and sync flush
// Ports: clk, rst (async, active-high), flush (sync, drops held entries),
//   in_valid/in_data/in_ready (upstream side, in_ready registered),
//   out_valid/out_data/out_ready (downstream side, outputs registered),
//   occupancy (held entries 0..2).
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);
  state_t state;
  logic mainValid, skidValid, mainEn, skidEn;
  logic [WIDTH-1:0] mainD, skidData;
  assign mainValid = state[0];
  assign skidValid = state[1];
  assign out_valid = mainValid;
  assign in_ready  = !skidValid;
  assign occupancy = OCC_W'(mainValid) + OCC_W'(skidValid);
  // Main reloads from the skid when draining FULL, otherwise from the input;
  // the skid only loads when BUSY is stalled and a new word arrives.
  assign mainEn = !flush && (state == ST_FULL ? out_ready : in_valid && (state == ST_EMPTY || out_ready));
  assign skidEn = !flush && state == ST_BUSY && in_valid && !out_ready;
  assign mainD  = state == ST_FULL ? skidData : in_data;
  reg_nb_en #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) uMain (
    .clk(clk), .rst(rst), .en(mainEn), .d(mainD), .q(out_data)
  );
  reg_nb_en #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) uSkid (
    .clk(clk), .rst(rst), .en(skidEn), .d(in_data), .q(skidData)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_EMPTY;
    else if (flush) state <= ST_EMPTY;
    else
      case (state)
        ST_EMPTY: state <= in_valid ? ST_BUSY : ST_EMPTY;
        ST_BUSY:  state <= (in_valid && !out_ready) ? ST_FULL : (!in_valid && out_ready) ? ST_EMPTY : ST_BUSY;
        ST_FULL:  state <= out_ready ? ST_BUSY : ST_FULL;
        default:  state <= ST_EMPTY;
      endcase
  assert property (@(posedge clk) disable iff (rst) !(skidValid && !mainValid));
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: scoreboard bench driving a 16-bit and a 37-bit instance with identical handshakes
module tb_pipe_skid_reg;
  logic clk = 0;
  logic rst, flush, in_valid, out_ready;
  logic [36:0] inData;
  logic [15:0] inData16;
  logic ir16, ov16, ir37, ov37;
  logic [15:0] od16;
  logic [36:0] od37;
  logic [1:0] occ16, occ37;
  int checks = 0, errors = 0;
  logic [36:0] exp[$];
  logic [36:0] outLog[$];
  logic room, stallPrev = 0, sawDead = 0;
  logic [36:0] prevData;
  int base;

  always #5 clk = ~clk;
  assign inData16 = inData[15:0];

  pipe_skid_reg u16 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(inData16),
    .in_ready(ir16), .out_valid(ov16), .out_data(od16), .out_ready(out_ready), .occupancy(occ16)
  );
  pipe_skid_reg #(.WIDTH(37), .RESET_VAL(37'h1F)) u37 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(inData),
    .in_ready(ir37), .out_valid(ov37), .out_data(od37), .out_ready(out_ready), .occupancy(occ37)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [36:0] d, input logic r, input logic f);
    in_valid = v;
    inData = d;
    out_ready = r;
    flush = f;
    @(posedge clk);
    #1;
  endtask

  // Monitor/scoreboard: the queue holds exactly the words the stage should be holding,
  // front = word on the output. Checks current outputs, then applies the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      exp.delete();
      chk("rst_valid16", ov16, 0);
      chk("rst_valid37", ov37, 0);
      chk("rst_ready16", ir16, 1);
      chk("rst_ready37", ir37, 1);
      chk("rst_occ16", occ16, 0);
      chk("rst_occ37", occ37, 0);
      chk("rst_data16", od16, 16'h0000);
      chk("rst_data37", od37, 37'h1F);
    end else begin
      chk("occ16", occ16, exp.size());
      chk("occ37", occ37, exp.size());
      chk("valid16", ov16, exp.size() > 0);
      chk("valid37", ov37, exp.size() > 0);
      chk("ready16", ir16, exp.size() < 2);
      chk("ready37", ir37, exp.size() < 2);
      if (exp.size() > 0) begin
        chk("data16", od16, exp[0][15:0]);
        chk("data37", od37, exp[0]);
      end
      if (stallPrev) chk("stall_hold", od37, prevData);
      if (ov16 && od16 == 16'hDEAD) sawDead = 1;
      room = exp.size() < 2;
      if (exp.size() > 0 && out_ready) begin
        outLog.push_back(od37);
        void'(exp.pop_front());
      end
      if (flush) exp.delete();
      else if (in_valid && room) exp.push_back(inData);
    end
    stallPrev = !rst && ov37 && !out_ready && !flush;
    prevData = od37;
  end

  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; inData = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    // reset while holding two words with a word still being offered
    drive(1, 37'h1111, 0, 0);
    drive(1, 37'h2222, 0, 0);
    rst = 1;
    repeat (3) drive(1, 37'h5555, 1, 0);
    rst = 0;
    drive(1, 37'h1234, 0, 0);
    chk("rst_first_valid", ov16, 1);
    chk("rst_first_word", od16, 16'h1234);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    // streaming at one word per cycle
    base = outLog.size();
    for (int i = 1; i <= 16; i++) drive(1, 37'(i), 1, 0);
    drive(0, 0, 1, 0);
    chk("stream_count", outLog.size() - base, 16);
    for (int i = 0; i < 16; i++) chk("stream_order", outLog[base + i], 37'(i + 1));
    // backpressure into the skid entry
    base = outLog.size();
    drive(1, 37'hAAAA, 0, 0);
    drive(1, 37'hBBBB, 0, 0);
    chk("bp_occ", occ16, 2);
    chk("bp_ready", ir16, 0);
    chk("bp_data", od16, 16'hAAAA);
    drive(1, 37'hCCCC, 0, 0);
    chk("bp_occ_hold", occ37, 2);
    chk("bp_data_hold", od37, 37'hAAAA);
    drive(1, 37'hCCCC, 1, 0);
    drive(1, 37'hCCCC, 1, 0);
    drive(0, 0, 1, 0);
    chk("bp_count", outLog.size() - base, 3);
    chk("bp_out0", outLog[base], 37'hAAAA);
    chk("bp_out1", outLog[base + 1], 37'hBBBB);
    chk("bp_out2", outLog[base + 2], 37'hCCCC);
    // flush while FULL, with an offered word and an output handshake in the same cycle
    drive(1, 37'h1111, 0, 0);
    drive(1, 37'h2222, 0, 0);
    chk("fl_pre_occ", occ16, 2);
    base = outLog.size();
    drive(1, 37'hDEAD, 1, 1);
    chk("fl_occ", occ16, 0);
    chk("fl_valid", ov37, 0);
    chk("fl_ready", ir37, 1);
    chk("fl_delivered", outLog.size() - base, 1);
    chk("fl_delivered_word", outLog[base], 37'h1111);
    repeat (3) drive(0, 0, 1, 0);
    chk("fl_no_dead", sawDead, 0);
    // random valid/ready/flush traffic
    for (int i = 0; i < 10000; i++)
      drive($urandom_range(0, 3) != 0, {5'($urandom), $urandom}, $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
    repeat (3) drive(0, 0, 1, 0);
    chk("end_occ", occ37, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised pipeline register stage. Generalises the fixed 16-bit enable register to any width.
- Adds a valid/ready handshake on both sides, a 2-entry skid buffer and synchronous flush.
- Sits between pipeline stages, e.g. processor-to-cache request path and fill/response path.
- Registered in_ready breaks the combinational ready chain while still sustaining 1 transfer/cycle.

Parameters:
- WIDTH, 16, payload width in bits (>=1).
- RESET_VAL, 0, value held by both data registers after reset (WIDTH bits).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous flush; drops all held entries.
- in_valid  input  1  upstream has a word on in_data.
- in_data  input  WIDTH  upstream payload.
- in_ready  output  1  stage can accept; registered (= !skid_valid).
- out_valid  output  1  main entry holds a word (= main_valid).
- out_data  output  WIDTH  main entry payload.
- out_ready  input  1  downstream accepts this cycle.
- occupancy  output  2  number of held entries: 0, 1 or 2.

Behaviour:
- Transfer definitions: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready, both at the rising edge.
- Storage: main entry (main_valid, main_data) and skid entry (skid_valid, skid_data).
- Reset (async, while rst=1): main_valid=0, skid_valid=0, main_data=skid_data=RESET_VAL.
  - Resulting outputs: out_valid=0, out_data=RESET_VAL, in_ready=1, occupancy=0.
  - Reset mid-transfer discards both entries; no partial word survives.
- State encoding: EMPTY (00), BUSY (main only), FULL (main+skid). Skid valid without main valid is illegal; assertion required.
- EMPTY:
  - in_valid: main<=in_data, go BUSY.
  - Otherwise stay.
  - out_ready is ignored.
- BUSY:
  - in_valid & out_ready: main<=in_data, stay BUSY (throughput 1/cycle).
  - in_valid & !out_ready: skid<=in_data, go FULL.
  - !in_valid & out_ready: go EMPTY. main_data is held, not cleared.
  - Neither: hold.
- FULL:
  - in_ready=0, so in_valid is ignored.
  - out_ready: main<=skid, skid_valid<=0, go BUSY.
  - Otherwise hold.
- Ordering: strictly FIFO; the skid word is always output after the current main word.
- Latency: a word accepted into EMPTY appears on out_data/out_valid the next cycle. No combinational path from in_* to out_*, or from out_ready to in_ready.
- Flush (synchronous, highest priority below rst): next state EMPTY, both valids cleared.
  - Data registers are held, not cleared.
  - An input presented in the flush cycle is dropped even if in_ready=1.
  - An output handshake in the flush cycle still counts as delivered; the bench must not count it as dropped.
- Data-enable gating: data registers load only on the transitions above; no other cycle changes out_data.
- occupancy = main_valid + skid_valid, 2 bits, no wrap.
- Stability: while out_valid=1 and out_ready=0, out_data and out_valid must not change (except on flush/rst).

Decomposition:
- Shared package pipe_pkg:
  - State encoding constants ST_EMPTY, ST_BUSY, ST_FULL.
  - Occupancy width constant (2).
- One sub-module, reg_nb_en: parametrised WIDTH-bit register with enable, async active-high reset to RESET_VAL.
  - Instantiated twice, for main_data and skid_data.
  - Valid bits and state live in the top.

Test Plan:
- Reset: assert rst for 3 cycles mid-stream with in_valid=1 -> out_valid=0, in_ready=1, occupancy=0, out_data=16'h0000 during and after; first post-reset word 16'h1234 appears on out_data 1 cycle after acceptance.
- Streaming: in_valid=1 and out_ready=1 continuously, data 16'h0001..16'h0010 -> 16 outputs in order, one per cycle, in_ready never drops, occupancy stays 1.
- Backpressure/skid: push 16'hAAAA, then 16'hBBBB with out_ready=0 -> occupancy=2, in_ready=0, out_data=16'hAAAA held; 16'hCCCC presented is not accepted. Release out_ready -> outputs AAAA, BBBB, CCCC in order.
- Flush in FULL: occupancy=2, flush=1 with in_valid=1 and data 16'hDEAD -> next cycle occupancy=0, out_valid=0, in_ready=1; DEAD never appears on the output.
- Random valid/ready (10k cycles, WIDTH=37, RESET_VAL=37'h1F) -> scoreboard shows no loss, duplication or reordering; out_data stable while stalled; occupancy always equals the scoreboard count.
